// File: rtl/galois_pow_inv_7_seq.sv
`default_nettype none
// ============================================================================
// Module   : galois_pow_inv_7_seq
// Purpose  : BN254 field exponentiation base^exponent by left-to-right
//            square-and-multiply on a borrowed request/ack field multiplier.
//            Macro GALOIS_POW_INV_7_CHECK_EN adds a y^7 == base self-check.
// Revision : 1.0 - initial release
// ============================================================================
module galois_pow_inv_7_seq #(
    parameter int N_BITS = 254
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_BITS-1:0] base,
    input  logic [N_BITS-1:0] exponent,
    output logic              busy,
    output logic [N_BITS-1:0] result,
    output logic              ready,
    output logic              mul_req,
    output logic [N_BITS-1:0] mul_a,
    output logic [N_BITS-1:0] mul_b,
    input  logic              mul_ack,
    input  logic [N_BITS-1:0] mul_p,
    output logic              check_err
);

    localparam int                 C_IDX_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [C_IDX_W-1:0] C_IDX_TOP = C_IDX_W'(N_BITS - 1);
    localparam logic [N_BITS-1:0]  C_ONE     = N_BITS'(1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_SCAN      = 4'd1,
        S_SQ_WAIT   = 4'd2,
        S_MUL_WAIT  = 4'd3,
        S_DONE      = 4'd4
`ifdef GALOIS_POW_INV_7_CHECK_EN
        ,
        S_CHK_SQ    = 4'd5,
        S_CHK1_WAIT = 4'd6,
        S_CHK2_WAIT = 4'd7,
        S_CHK3_WAIT = 4'd8,
        S_CHK4_WAIT = 4'd9
`endif
    } state_t;

    // Where the main loop goes once bit 0 has been consumed
`ifdef GALOIS_POW_INV_7_CHECK_EN
    localparam state_t C_LOOP_EXIT = S_CHK_SQ;
`else
    localparam state_t C_LOOP_EXIT = S_DONE;
`endif

    state_t              r_state;
    logic [N_BITS-1:0]   r_base;
    logic [N_BITS-1:0]   r_exp;
    logic [N_BITS-1:0]   r_acc;
    logic [C_IDX_W-1:0]  r_idx;
    logic                r_started;

    logic                w_bit;
    logic                w_last;

    assign w_bit  = r_exp[r_idx];
    assign w_last = (r_idx == '0);

`ifdef GALOIS_POW_INV_7_CHECK_EN
    logic r_chk_fail;
    logic r_check_err;
    assign check_err = r_check_err;
`else
    assign check_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_exp     <= '0;
            r_acc     <= '0;
            r_idx     <= '0;
            r_started <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b0;
            result    <= '0;
            mul_req   <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
`ifdef GALOIS_POW_INV_7_CHECK_EN
            r_chk_fail  <= 1'b0;
            r_check_err <= 1'b0;
`endif
        end else begin
            ready   <= 1'b0;
            mul_req <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base    <= base;
                        r_exp     <= exponent;
                        r_idx     <= C_IDX_TOP;
                        r_acc     <= C_ONE;
                        r_started <= 1'b0;
                        busy      <= 1'b1;
`ifdef GALOIS_POW_INV_7_CHECK_EN
                        r_chk_fail  <= 1'b0;
                        r_check_err <= 1'b0;
`endif
                        r_state   <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    if (r_started) begin
                        mul_req <= 1'b1;
                        mul_a   <= r_acc;
                        mul_b   <= r_acc;
                        r_state <= S_SQ_WAIT;
                    end else begin
                        // Leading bits cost one cycle each; the first set bit seeds acc
                        if (w_bit) begin
                            r_acc     <= r_base;
                            r_started <= 1'b1;
                        end
                        if (w_last) begin
                            r_state <= C_LOOP_EXIT;
                        end else begin
                            r_idx   <= r_idx - 1'b1;
                            r_state <= S_SCAN;
                        end
                    end
                end

                S_SQ_WAIT: begin
                    if (mul_ack) begin
                        r_acc <= mul_p;
                        if (w_bit) begin
                            mul_req <= 1'b1;
                            mul_a   <= mul_p;
                            mul_b   <= r_base;
                            r_state <= S_MUL_WAIT;
                        end else if (w_last) begin
                            r_state <= C_LOOP_EXIT;
                        end else begin
                            r_idx   <= r_idx - 1'b1;
                            r_state <= S_SCAN;
                        end
                    end
                end

                S_MUL_WAIT: begin
                    if (mul_ack) begin
                        r_acc <= mul_p;
                        if (w_last) begin
                            r_state <= C_LOOP_EXIT;
                        end else begin
                            r_idx   <= r_idx - 1'b1;
                            r_state <= S_SCAN;
                        end
                    end
                end

`ifdef GALOIS_POW_INV_7_CHECK_EN
                // acc holds y; the chain y2, y3, y6, y7 rides on mul_p
                S_CHK_SQ: begin
                    mul_req <= 1'b1;
                    mul_a   <= r_acc;
                    mul_b   <= r_acc;
                    r_state <= S_CHK1_WAIT;
                end

                S_CHK1_WAIT: begin
                    if (mul_ack) begin
                        mul_req <= 1'b1;
                        mul_a   <= mul_p;
                        mul_b   <= r_acc;
                        r_state <= S_CHK2_WAIT;
                    end
                end

                S_CHK2_WAIT: begin
                    if (mul_ack) begin
                        mul_req <= 1'b1;
                        mul_a   <= mul_p;
                        mul_b   <= mul_p;
                        r_state <= S_CHK3_WAIT;
                    end
                end

                S_CHK3_WAIT: begin
                    if (mul_ack) begin
                        mul_req <= 1'b1;
                        mul_a   <= mul_p;
                        mul_b   <= r_acc;
                        r_state <= S_CHK4_WAIT;
                    end
                end

                S_CHK4_WAIT: begin
                    if (mul_ack) begin
                        r_chk_fail <= (mul_p != r_base);
                        r_state    <= S_DONE;
                    end
                end
`endif

                S_DONE: begin
                    result  <= r_acc;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
`ifdef GALOIS_POW_INV_7_CHECK_EN
                    r_check_err <= r_chk_fail;
`endif
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_galois_pow_inv_7_seq.sv
`default_nettype none
// Testbench for galois_pow_inv_7_seq: field-multiplier model with fixed latency,
// random operands checked against a plain modular-exponentiation reference.
module tb_galois_pow_inv_7_seq;

    localparam int N     = 254;
    localparam int L     = 13;
    localparam int LIMIT = 12000;
    localparam logic [255:0] PW = 256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] base = '0;
    logic [N-1:0] exponent = '0;
    logic         busy, ready, mul_req, check_err;
    logic [N-1:0] result, mul_a, mul_b;
    logic         mul_ack;
    logic [N-1:0] mul_p;

    int checks = 0;
    int passed = 0;
    int req_cnt = 0;
    int rdy_cnt = 0;
    int viol = 0;
    bit outstanding = 1'b0;
    logic [N-1:0] inv7;

    galois_pow_inv_7_seq #(.N_BITS(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .exponent(exponent),
        .busy(busy), .result(result), .ready(ready),
        .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b),
        .mul_ack(mul_ack), .mul_p(mul_p), .check_err(check_err)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] fmul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [511:0] t;
        t = ({258'b0, a} * {258'b0, b}) % {256'b0, PW};
        return t[N-1:0];
    endfunction

    function automatic logic [N-1:0] fpow(input logic [N-1:0] x, input logic [N-1:0] e);
        logic [N-1:0] r, s;
        r = N'(1);
        s = x;
        for (int i = 0; i < N; i++) begin
            if (e[i]) r = fmul(r, s);
            s = fmul(s, s);
        end
        return r;
    endfunction

    function automatic logic [N-1:0] rnd_fe();
        logic [255:0] t;
        logic [511:0] w;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom();
        w = {256'b0, t} % {256'b0, PW};
        return w[N-1:0];
    endfunction

    function automatic logic [N-1:0] calc_inv7();
        logic [511:0] t, pm1;
        logic [N-1:0] d;
        d = '0;
        pm1 = {256'b0, PW} - 512'd1;
        for (int k = 1; k < 7; k++) begin
            t = 512'(k) * pm1 + 512'd1;
            if (t % 512'd7 == 512'd0) d = N'(t / 512'd7);
        end
        return d;
    endfunction

    function automatic int exp_reqs(input logic [N-1:0] e);
        int b = 0;
        int w = 0;
        int n;
        for (int i = 0; i < N; i++) if (e[i]) begin w++; b = i + 1; end
        n = (w == 0) ? 0 : (b - 1) + (w - 1);
`ifdef GALOIS_POW_INV_7_CHECK_EN
        n += 4;
`endif
        return n;
    endfunction

    function automatic logic exp_chk(input logic [N-1:0] b, input logic [N-1:0] e);
`ifdef GALOIS_POW_INV_7_CHECK_EN
        return fpow(fpow(b, e), N'(7)) != b;
`else
        return (b != b) || (e != e);
`endif
    endfunction

    // Shared field multiplier: fixed latency L from request to ack
    logic [N-1:0] mq_a, mq_b;
    int           mq_cnt;
    bit           mq_busy;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq_busy <= 1'b0; mq_cnt <= 0; mq_a <= '0; mq_b <= '0;
            mul_ack <= 1'b0; mul_p <= '0;
        end else begin
            mul_ack <= 1'b0;
            if (mq_busy) begin
                if (mq_cnt <= 1) begin
                    mul_ack <= 1'b1; mul_p <= fmul(mq_a, mq_b); mq_busy <= 1'b0;
                end else mq_cnt <= mq_cnt - 1;
            end
            if (mul_req) begin
                mq_busy <= 1'b1; mq_a <= mul_a; mq_b <= mul_b; mq_cnt <= L - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) outstanding = 1'b0;
        else begin
            if (mul_ack) outstanding = 1'b0;
            if (mul_req) begin
                if (outstanding) viol++;
                outstanding = 1'b1;
                req_cnt++;
            end
            if (ready) rdy_cnt++;
        end
    end

    task automatic do_op(input logic [N-1:0] b, input logic [N-1:0] e, output int cyc, output bit to);
        @(negedge clk); base = b; exponent = e; start = 1'b1;
        @(negedge clk); start = 1'b0; base = rnd_fe(); exponent = rnd_fe();
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!ready && cyc < LIMIT);
        to = !ready;
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        checks++; if (ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ready); else passed++;
        checks++; if (mul_req !== 1'b0) $display("FAIL reset_mul_req got=%b exp=0", mul_req); else passed++;
        checks++; if (check_err !== 1'b0) $display("FAIL reset_check_err got=%b exp=0", check_err); else passed++;
        checks++; if (result !== '0) $display("FAIL reset_result got=%h exp=0", result); else passed++;
        checks++; if (mul_a !== '0 || mul_b !== '0) $display("FAIL reset_operands got=%h/%h exp=0", mul_a, mul_b); else passed++;
    endtask

    task automatic test_basic();
        int r0, q0, cyc; bit to;
        r0 = rdy_cnt; q0 = req_cnt;
        do_op(N'(2), N'(3), cyc, to);
        checks++; if (to) $display("FAIL basic_timeout got=no_ready exp=ready"); else passed++;
        checks++; if (result !== N'(8)) $display("FAIL basic_result got=%h exp=8", result); else passed++;
        checks++; if (check_err !== exp_chk(N'(2), N'(3))) $display("FAIL basic_check_err got=%b", check_err); else passed++;
        repeat (3) @(posedge clk); #1;
        checks++; if (req_cnt - q0 != exp_reqs(N'(3))) $display("FAIL basic_reqs got=%0d exp=%0d", req_cnt - q0, exp_reqs(N'(3))); else passed++;
        checks++; if (rdy_cnt - r0 != 1) $display("FAIL basic_ready_count got=%0d exp=1", rdy_cnt - r0); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL basic_busy_after got=%b exp=0", busy); else passed++;
        checks++; if (result !== N'(8)) $display("FAIL basic_result_held got=%h exp=8", result); else passed++;
    endtask

    task automatic test_exp_zero();
        int q0, cyc; bit to;
        q0 = req_cnt;
        do_op(N'(5), N'(0), cyc, to);
        checks++; if (to) $display("FAIL exp0_timeout got=no_ready exp=ready"); else passed++;
        checks++; if (result !== N'(1)) $display("FAIL exp0_result got=%h exp=1", result); else passed++;
`ifndef GALOIS_POW_INV_7_CHECK_EN
        checks++; if (cyc != N + 1) $display("FAIL exp0_latency got=%0d exp=%0d", cyc, N + 1); else passed++;
`endif
        checks++; if (check_err !== exp_chk(N'(5), N'(0))) $display("FAIL exp0_check_err got=%b", check_err); else passed++;
        repeat (2) @(posedge clk); #1;
        checks++; if (req_cnt - q0 != exp_reqs(N'(0))) $display("FAIL exp0_reqs got=%0d exp=%0d", req_cnt - q0, exp_reqs(N'(0))); else passed++;
    endtask

    task automatic test_base_zero_and_one();
        int q0, cyc; bit to;
        q0 = req_cnt;
        do_op(N'(0), N'(5), cyc, to);
        checks++; if (to || result !== N'(0)) $display("FAIL base0_result got=%h exp=0 timeout=%b", result, to); else passed++;
        repeat (2) @(posedge clk); #1;
        checks++; if (req_cnt - q0 != exp_reqs(N'(5))) $display("FAIL base0_reqs got=%0d exp=%0d", req_cnt - q0, exp_reqs(N'(5))); else passed++;
        q0 = req_cnt;
        do_op(N'(1), N'(1), cyc, to);
        checks++; if (to || result !== N'(1)) $display("FAIL exp1_result got=%h exp=1 timeout=%b", result, to); else passed++;
        repeat (2) @(posedge clk); #1;
        checks++; if (req_cnt - q0 != exp_reqs(N'(1))) $display("FAIL exp1_reqs got=%0d exp=%0d", req_cnt - q0, exp_reqs(N'(1))); else passed++;
    endtask

    task automatic test_inv7_roundtrip();
        logic [N-1:0] x, b;
        int q0, cyc; bit to;
        for (int it = 0; it < 2; it++) begin
            x = rnd_fe();
            b = fpow(x, N'(7));
            q0 = req_cnt;
            do_op(b, inv7, cyc, to);
            checks++; if (to || result !== x) $display("FAIL inv7_result got=%h exp=%h timeout=%b", result, x, to); else passed++;
            checks++; if (check_err !== 1'b0) $display("FAIL inv7_check_err got=%b exp=0", check_err); else passed++;
            repeat (2) @(posedge clk); #1;
            checks++; if (req_cnt - q0 != exp_reqs(inv7)) $display("FAIL inv7_reqs got=%0d exp=%0d", req_cnt - q0, exp_reqs(inv7)); else passed++;
        end
    endtask

    task automatic test_random();
        logic [N-1:0] b, e, exp_r;
        int q0, cyc; bit to;
        for (int it = 0; it < 4; it++) begin
            b = rnd_fe();
            e = (it < 1) ? rnd_fe() : N'($urandom_range(2, 65535));
            exp_r = fpow(b, e);
            q0 = req_cnt;
            do_op(b, e, cyc, to);
            checks++; if (to || result !== exp_r) $display("FAIL rand_result got=%h exp=%h timeout=%b", result, exp_r, to); else passed++;
            checks++; if (check_err !== exp_chk(b, e)) $display("FAIL rand_check_err got=%b exp=%b", check_err, exp_chk(b, e)); else passed++;
            repeat (2) @(posedge clk); #1;
            checks++; if (req_cnt - q0 != exp_reqs(e)) $display("FAIL rand_reqs got=%0d exp=%0d", req_cnt - q0, exp_reqs(e)); else passed++;
        end
        checks++; if (viol != 0) $display("FAIL req_discipline got=%0d overlaps exp=0", viol); else passed++;
    endtask

    task automatic test_check();
        int q0, cyc; bit to;
        q0 = req_cnt;
        do_op(N'(3), N'(2), cyc, to);
        checks++; if (to || result !== N'(9)) $display("FAIL chk_result got=%h exp=9 timeout=%b", result, to); else passed++;
        checks++; if (check_err !== exp_chk(N'(3), N'(2))) $display("FAIL chk_flag got=%b exp=%b", check_err, exp_chk(N'(3), N'(2))); else passed++;
        repeat (2) @(posedge clk); #1;
        checks++; if (req_cnt - q0 != exp_reqs(N'(2))) $display("FAIL chk_reqs got=%0d exp=%0d", req_cnt - q0, exp_reqs(N'(2))); else passed++;
    endtask

    task automatic test_start_ignored();
        int r0, cyc;
        r0 = rdy_cnt;
        @(negedge clk); base = N'(2); exponent = N'(3); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        base = N'(5); exponent = N'(7); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++; if (check_err !== 1'b0) $display("FAIL start_clears_check_err got=%b exp=0", check_err); else passed++;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!ready && cyc < LIMIT);
        checks++; if (!ready || result !== N'(8)) $display("FAIL busy_start_result got=%h exp=8 ready=%b", result, ready); else passed++;
        repeat (60) @(posedge clk); #1;
        checks++; if (rdy_cnt - r0 != 1) $display("FAIL busy_start_ready_count got=%0d exp=1", rdy_cnt - r0); else passed++;
        checks++; if (result !== N'(8) || busy !== 1'b0) $display("FAIL busy_start_held got=%h busy=%b exp=8/0", result, busy); else passed++;
    endtask

    task automatic test_reset_mid();
        int r0, cyc; bit to;
        @(negedge clk); base = N'(2); exponent = N'(3); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!mul_req && cyc < 400);
        checks++; if (!mul_req) $display("FAIL rstmid_no_square got=0 exp=1"); else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b0; #1;
        r0 = rdy_cnt;
        checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else passed++;
        checks++; if (result !== '0) $display("FAIL rstmid_result got=%h exp=0", result); else passed++;
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (40) @(posedge clk); #1;
        checks++; if (rdy_cnt != r0 || busy !== 1'b0) $display("FAIL rstmid_no_ready got=%0d busy=%b exp=0/0", rdy_cnt - r0, busy); else passed++;
        do_op(N'(2), N'(3), cyc, to);
        checks++; if (to || result !== N'(8)) $display("FAIL rstmid_restart got=%h exp=8 timeout=%b", result, to); else passed++;
    endtask

    initial begin
        inv7 = calc_inv7();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_exp_zero();
        test_base_zero_and_one();
        test_inv7_roundtrip();
        test_random();
        test_check();
        test_start_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/galois_pow_inv_7_seq.md
Name: galois_pow_inv_7_seq

Overview:
- Sequential BN254 field exponentiation engine computing result = base^exponent mod p.
- Driven with exponent = inverse of 7 mod (p-1), it is the seventh-root (decrypt-direction) counterpart of the x^7 round power.
- Uses left-to-right square-and-multiply.
- Borrows a shared sync field multiplier through a request/acknowledge port; owns no multiplier itself.

Parameters:
- N_BITS, 254, width of field elements and of the exponent.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base  in  N_BITS  field element, latched on accepted start.
- exponent  in  N_BITS  exponent, latched on accepted start; top level ties it to the inverse-7 constant.
- busy  out  1  high from the cycle after an accepted start until ready.
- result  out  N_BITS  base^exponent; held stable until the next accepted start.
- ready  out  1  one-cycle pulse, result valid.
- mul_req  out  1  one-cycle multiply request.
- mul_a  out  N_BITS  operand A, valid with mul_req.
- mul_b  out  N_BITS  operand B, valid with mul_req.
- mul_ack  in  1  one-cycle pulse, product valid; latency L >= 1 cycles after mul_req.
- mul_p  in  N_BITS  product, valid with mul_ack.
- check_err  out  1  self-check failure flag (see Optional Feature).

Behaviour:
- Reset: state=IDLE; busy=0, ready=0, mul_req=0, check_err=0; result, mul_a, mul_b = 0. The multiplier shares rst_n.
- States: IDLE, SCAN, SQ_WAIT, MUL_WAIT, DONE (plus CHK states when the option is compiled in).
- IDLE, start=1: latch base and exponent, idx=N_BITS-1, acc=1, started=0, then go to SCAN.
- IDLE, start=0 or stray mul_ack: ignored.
- SCAN, started=0: bit idx=0 costs 1 cycle. Bit=1 sets acc=base and started=1 with no multiply.
- SCAN, started=1: issue mul_req with a=acc, b=acc, then go to SQ_WAIT.
- SQ_WAIT, mul_ack: acc=mul_p. If exp[idx]=1, issue mul_req (acc, base) in the same cycle and go to MUL_WAIT. Otherwise go to the bit-advance step.
- MUL_WAIT, mul_ack: acc=mul_p, then bit-advance.
- Bit-advance: idx==0 goes to DONE; otherwise idx-1 and back to SCAN.
- Leading-zero path in SCAN: idx==0 goes to DONE, else decrement.
- DONE: result=acc, ready=1 for one cycle, busy=0, return to IDLE. Total cycles are data-dependent.
- Request discipline: at most one outstanding mul_req; none issued while waiting for mul_ack.
- Request count: with b = bit length of the exponent and w = its popcount, exactly (b-1) squares plus (w-1) multiplies are requested.
- exponent=0: result=1, zero mul_req, ready exactly N_BITS+1 cycles after start.
- base=0 with exponent!=0: result=0 via the normal path; no special case.
- Operands are assumed < p; no reduction is done here.
- start while busy: ignored. Latched operands are unaffected by input changes.
- rst_n low mid-operation: immediate return to IDLE, no ready pulse, result cleared to 0.

Optional Feature:
- Macro GALOIS_POW_INV_7_CHECK_EN.
- Defined: after the main loop, compute y^7 with 4 further requests, in order: y*y, then y2*y, then y3*y3, then y6*y. Compare against the latched base.
- check_err is set with the ready pulse if they differ, and cleared on the next accepted start.
- Costs 4 extra mul_req; ready is delayed accordingly.
- Not defined: no CHK states, check_err tied 0, request counts exactly as above.

Test Plan:
- Multiplier model: field multiply, L=13. Reset, then exponent=3, base=2 -> result=8; exactly 2 mul_req (1 square, 1 multiply); one ready pulse; busy low afterwards.
- exponent=0, base=5 -> result=1; zero mul_req; ready exactly 255 cycles after start.
- exponent=5, base=0 -> result=0; 3 mul_req. Then exponent=1, base=1 -> result=1; 0 mul_req.
- exponent=inverse-7 constant, base=x^7 mod p from the pow-7 test vectors -> result=x. Check_err=0 when built with GALOIS_POW_INV_7_CHECK_EN. With the same option, exponent=2, base=3 -> result=9, check_err=1.
- start pulsed again 10 cycles into an operation with a different base -> ignored; the first result is unchanged and there is only one ready.
- rst_n low for 1 cycle mid-SQ_WAIT -> busy=0, result=0, no ready. A fresh start with exponent=3, base=2 then yields 8.
